lenet_image_loader: RTL and testbench

Upstream feeder for the LeNet accelerator. It accepts a row-major pixel stream over a valid/ready handshake and assembles complete IMG_DIM x IMG_DIM frames into two ping-pong register banks. While one bank holds a complete frame, it drives that frame as the parallel image array the accelerator consumes, and the other bank fills. Frames whose length does not match the pix_last marker are dropped, and an error is flagged.

---
 rtl/lenet_image_loader_if.sv | 26 ++
 rtl/lenet_image_loader.sv | 140 ++++++++++++++
 tb/tb_lenet_image_loader.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/lenet_image_loader_if.sv
// Pixel-stream and frame-output bundle for the LeNet image loader.
// master: pixel source plus frame consumer; slave: the loader itself.
interface lenet_image_loader_if #(
    parameter int unsigned bitwidth = 16,
    parameter int unsigned IMG_DIM  = 28
);
    logic signed [bitwidth-1:0]                   pix_in;
    logic                                         pix_valid;
    logic                                         pix_last;
    logic                                         pix_ready;
    logic [IMG_DIM-1:0][IMG_DIM-1:0][bitwidth-1:0] frame_out;
    logic                                         frame_valid;
    logic                                         frame_ack;
    logic [15:0]                                  frame_count;
    logic                                         err_len;

    modport master (
        output pix_in, pix_valid, pix_last, frame_ack,
        input  pix_ready, frame_out, frame_valid, frame_count, err_len
    );

    modport slave (
        input  pix_in, pix_valid, pix_last, frame_ack,
        output pix_ready, frame_out, frame_valid, frame_count, err_len
    );
endinterface

// File: rtl/lenet_image_loader.sv
// LeNet image loader: assembles a row-major pixel stream into two ping-pong
// frame banks. One committed bank is presented as frame_out while the other
// fills. Frames whose length disagrees with pix_last are dropped with err_len.
module lenet_image_loader #(
    parameter int unsigned bitwidth = 16,
    parameter int unsigned IMG_DIM  = 28
) (
    input logic                 clk,
    input logic                 rst,
    lenet_image_loader_if.slave bus
);
    localparam int unsigned     IdxW    = (IMG_DIM > 1) ? $clog2(IMG_DIM) : 1;
    localparam logic [IdxW-1:0] LastPos = IdxW'(IMG_DIM - 1);

    typedef logic [IMG_DIM-1:0][IMG_DIM-1:0][bitwidth-1:0] frame_t;
    typedef enum logic {StFill, StResync} state_e;

    state_e          state_q, state_d;
    frame_t          bank_q [2];
    logic [1:0]      full_q, full_d;
    logic            wr_bank_q, wr_bank_d;
    logic            rd_bank_q, rd_bank_d;
    logic [IdxW-1:0] row_q, row_d;
    logic [IdxW-1:0] col_q, col_d;
    logic [15:0]     frame_count_q, frame_count_d;
    logic            err_len_q, err_len_d;
    logic            frame_valid_q, frame_valid_d;

    logic pix_ready;
    logic accept;
    logic at_last;
    logic wr_en;

    // In RESYNC pixels are swallowed, so the source is never stalled there.
    assign pix_ready = (state_q == StResync) || !full_q[wr_bank_q];
    assign accept    = bus.pix_valid && pix_ready;
    assign at_last   = (row_q == LastPos) && (col_q == LastPos);

    assign bus.pix_ready   = pix_ready;
    assign bus.frame_out   = bank_q[rd_bank_q];
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_count = frame_count_q;
    assign bus.err_len     = err_len_q;

    // Next-state: frame release, pixel acceptance, length checking, bank flip.
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        full_d        = full_q;
        frame_count_d = frame_count_q;
        err_len_d     = 1'b0;
        wr_en         = 1'b0;

        // Release acts on rd_bank; a commit acts on wr_bank. When both fire
        // they touch different banks, so both updates compose.
        if (frame_valid_q && bus.frame_ack) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end

        if (accept) begin
            unique case (state_q)
                StFill: begin
                    if (!at_last && !bus.pix_last) begin
                        wr_en = 1'b1;
                        if (col_q == LastPos) begin
                            col_d = '0;
                            row_d = row_q + IdxW'(1);
                        end else begin
                            col_d = col_q + IdxW'(1);
                        end
                    end else if (at_last && bus.pix_last) begin
                        wr_en             = 1'b1;
                        full_d[wr_bank_q] = 1'b1;
                        wr_bank_d         = ~wr_bank_q;
                        row_d             = '0;
                        col_d             = '0;
                        frame_count_d     = frame_count_q + 16'd1;
                    end else begin
                        // Short or long frame: drop it, bank stays EMPTY.
                        err_len_d = 1'b1;
                        row_d     = '0;
                        col_d     = '0;
                        if (at_last) begin
                            state_d = StResync;
                        end
                    end
                end
                StResync: begin
                    if (bus.pix_last) begin
                        state_d = StFill;
                        row_d   = '0;
                        col_d   = '0;
                    end
                end
                default: ;
            endcase
        end

        frame_valid_d = full_d[rd_bank_d];
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StFill;
            full_q        <= 2'b00;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            row_q         <= '0;
            col_q         <= '0;
            frame_count_q <= 16'd0;
            err_len_q     <= 1'b0;
            frame_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            full_q        <= full_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            row_q         <= row_d;
            col_q         <= col_d;
            frame_count_q <= frame_count_d;
            err_len_q     <= err_len_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    // Bank storage: cleared on reset, one pixel written per accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q[0] <= '0;
            bank_q[1] <= '0;
        end else if (wr_en) begin
            bank_q[wr_bank_q][row_q][col_q] <= bus.pix_in;
        end
    end
endmodule

// File: tb/tb_lenet_image_loader.sv
// Directed bench for lenet_image_loader: single frames, backpressure with both
// banks full, short/long frame drops, mid-frame reset and ack-on-commit streaming.
module tb_lenet_image_loader;
    localparam int unsigned W = 16;
    localparam int unsigned D = 28;
    localparam int          N = D * D;

    typedef logic [D-1:0][D-1:0][W-1:0] frame_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    lenet_image_loader_if #(.bitwidth(W), .IMG_DIM(D)) bus ();

    lenet_image_loader #(.bitwidth(W), .IMG_DIM(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] pix_val(input int seed, input int i);
        return W'(seed * 1000 + i);
    endfunction

    function automatic frame_t exp_frame(input int seed);
        frame_t f;
        for (int r = 0; r < D; r++) begin
            for (int c = 0; c < D; c++) begin
                f[r][c] = pix_val(seed, r * D + c);
            end
        end
        return f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_frame(input string tag, input frame_t obs, input frame_t exp);
        int bad_idx;
        bad_idx = -1;
        checks++;
        assert (obs === exp) else begin
            errors++;
            for (int i = N - 1; i >= 0; i--) begin
                if (obs[i / D][i % D] !== exp[i / D][i % D]) bad_idx = i;
            end
            if (bad_idx < 0) bad_idx = 0;
            $error("FAIL %s first bad pixel %0d observed=%0h expected=%0h", tag, bad_idx,
                   obs[bad_idx / D][bad_idx % D], exp[bad_idx / D][bad_idx % D]);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic push(input logic [W-1:0] v, input bit last, input bit ack);
        int n;
        bit taken;
        n     = 0;
        taken = 1'b0;
        bus.pix_in    = v;
        bus.pix_valid = 1'b1;
        bus.pix_last  = last;
        while (!taken) begin
            taken         = bus.pix_ready;
            bus.frame_ack = ack && taken;
            @(negedge clk);
            n++;
            if (!taken && n > 4000) begin
                checks++;
                errors++;
                $display("FAIL push_timeout observed=stalled expected=accepted");
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $fatal(1, "pixel never accepted");
            end
        end
        bus.pix_valid = 1'b0;
        bus.pix_last  = 1'b0;
        bus.frame_ack = 1'b0;
    endtask

    task automatic push_range(input int seed, input int from, input int to, input int last_at,
                              input bit ack_last, input bit gaps);
        for (int i = from; i <= to; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            push(pix_val(seed, i), i == last_at, ack_last && (i == last_at));
        end
    endtask

    task automatic ack_pulse();
        bus.frame_ack = 1'b1;
        @(negedge clk);
        bus.frame_ack = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.pix_in    = '0;
        bus.pix_valid = 1'b0;
        bus.pix_last  = 1'b0;
        bus.frame_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_valid", bus.frame_valid, 0);
        chk("rst_ready", bus.pix_ready, 1);
        chk("rst_count", bus.frame_count, 0);
        chk("rst_err", bus.err_len, 0);
        chk_frame("rst_frame", bus.frame_out, '0);

        // 1: one clean frame, pixel = index
        push_range(0, 0, N - 2, -1, 0, 0);
        chk("t1_valid_before_last", bus.frame_valid, 0);
        push(pix_val(0, N - 1), 1'b1, 1'b0);
        chk("t1_valid", bus.frame_valid, 1);
        chk("t1_px_0_0", bus.frame_out[0][0], 0);
        chk("t1_px_0_27", bus.frame_out[0][27], 27);
        chk("t1_px_27_27", bus.frame_out[27][27], 783);
        chk("t1_count", bus.frame_count, 1);
        chk_frame("t1_frame", bus.frame_out, exp_frame(0));

        // 2: fill bank 1 without ack, then both banks full
        push_range(1, 0, N - 1, N - 1, 0, 0);
        chk("t2_count", bus.frame_count, 2);
        chk("t2_valid", bus.frame_valid, 1);
        chk("t2_ready_full", bus.pix_ready, 0);
        chk_frame("t2_hold0", bus.frame_out, exp_frame(0));
        bus.pix_in    = pix_val(2, 0);
        bus.pix_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("t2_ready_held", bus.pix_ready, 0);
        chk_frame("t2_still0", bus.frame_out, exp_frame(0));
        ack_pulse();
        chk("t2_ready_after_ack", bus.pix_ready, 1);
        chk("t2_valid_after_ack", bus.frame_valid, 1);
        chk_frame("t2_frame1", bus.frame_out, exp_frame(1));
        push_range(2, 0, N - 1, N - 1, 0, 0);
        chk("t2_count3", bus.frame_count, 3);
        chk_frame("t2_hold1", bus.frame_out, exp_frame(1));
        ack_pulse();
        chk_frame("t2_frame2", bus.frame_out, exp_frame(2));
        ack_pulse();
        chk("t2_drained_valid", bus.frame_valid, 0);
        chk("t2_drained_ready", bus.pix_ready, 1);
        ack_pulse();
        chk("t2_spurious_ack", bus.frame_valid, 0);

        // 3: short frame (pix_last at index 99)
        push_range(3, 0, 99, 99, 0, 0);
        chk("t3_err_pulse", bus.err_len, 1);
        chk("t3_count", bus.frame_count, 3);
        chk("t3_valid", bus.frame_valid, 0);
        @(negedge clk);
        chk("t3_err_single", bus.err_len, 0);
        push_range(4, 0, N - 1, N - 1, 0, 0);
        chk("t3_valid_after", bus.frame_valid, 1);
        chk("t3_count_after", bus.frame_count, 4);
        chk("t3_px_0_0", bus.frame_out[0][0], 4000);
        chk_frame("t3_frame4", bus.frame_out, exp_frame(4));

        // 4: long frame (790 pixels)
        push_range(5, 0, N - 1, -1, 0, 0);
        chk("t4_err_pulse", bus.err_len, 1);
        chk("t4_count", bus.frame_count, 4);
        push(pix_val(5, N), 1'b0, 1'b0);
        chk("t4_err_single", bus.err_len, 0);
        chk("t4_resync_ready", bus.pix_ready, 1);
        push_range(5, N + 1, N + 5, N + 5, 0, 0);
        chk("t4_no_second_err", bus.err_len, 0);
        chk("t4_count_resync", bus.frame_count, 4);
        chk_frame("t4_hold4", bus.frame_out, exp_frame(4));
        push_range(6, 0, N - 1, N - 1, 0, 0);
        chk("t4_count_after", bus.frame_count, 5);
        ack_pulse();
        chk_frame("t4_frame6", bus.frame_out, exp_frame(6));

        // 5: reset mid-frame with one bank full
        push_range(7, 0, 399, -1, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_valid", bus.frame_valid, 0);
        chk("t5_ready", bus.pix_ready, 1);
        chk("t5_count", bus.frame_count, 0);
        chk("t5_err", bus.err_len, 0);
        chk_frame("t5_frame", bus.frame_out, '0);

        // 6: gapped stream, each commit coincides with ack of the other bank
        push_range(10, 0, N - 1, N - 1, 0, 1);
        chk("t6_first_valid", bus.frame_valid, 1);
        chk_frame("t6_frame10", bus.frame_out, exp_frame(10));
        for (int k = 1; k <= 10; k++) begin
            push_range(10 + k, 0, 399, -1, 0, 1);
            chk("t6_valid_mid", bus.frame_valid, 1);
            push_range(10 + k, 400, N - 1, N - 1, 1, 1);
            chk("t6_valid_commit", bus.frame_valid, 1);
            chk("t6_ready_commit", bus.pix_ready, 1);
            chk("t6_count", bus.frame_count, 32'(k + 1));
            chk_frame("t6_frame", bus.frame_out, exp_frame(10 + k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
